// File: rtl/galpal_22V10_pkg.sv
// Shared constants for the 22V10 fuse loader: map geometry, fuse-map row offsets, loader state.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FUSE_BITS/NBYTES/CSUM_W, AR/SP rows, OLMC select/enable/sum bases, loader_state_t.
package galpal_22V10_pkg;

    localparam int FUSE_BITS = 5892;
    localparam int NBYTES    = (FUSE_BITS + 7) / 8;   // 737
    localparam int CSUM_W    = 16;
    localparam int CNT_W     = 10;

    // Fuse-map layout: 44 fuses per row, rows listed as first fuse index.
    localparam int ROW_FUSES     = 44;
    localparam int AR_ROW        = 0;
    localparam int SP_ROW        = 5764;
    localparam int OLMC_SEL_BASE = 5808;   // S0/S1 pairs for the 10 OLMCs
    localparam int OLMC_SEL_LAST = 5827;
    localparam int N_OLMC        = 10;

    // Output-enable row of each OLMC; its sum terms start on the next row.
    // Product-term counts per OLMC: 8,10,12,14,16,16,14,12,10,8.
    localparam int OLMC_EN_BASE [N_OLMC] =
        '{44, 440, 924, 1496, 2156, 2904, 3652, 4312, 4884, 5368};
    localparam int OLMC_SUM_BASE [N_OLMC] =
        '{88, 484, 968, 1540, 2200, 2948, 3696, 4356, 4928, 5412};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

endpackage

// File: rtl/galpal_22v10_fuse_loader_if.sv
// Byte-stream load bus and fuse-map result of the 22V10 fuse loader.
// Latency: n/a (wiring only).
// Backpressure: D_VALID/D_READY; a byte moves when both are high at a clock edge.
// master = byte source / observer, slave = loader.
interface galpal_22v10_fuse_loader_if;

    logic                                      START;
    logic [7:0]                                D;
    logic                                      D_VALID;
    logic                                      D_READY;
    logic [galpal_22V10_pkg::CSUM_W-1:0]       CSUM_EXP;
    logic [galpal_22V10_pkg::FUSE_BITS-1:0]    FUSE;
    logic [galpal_22V10_pkg::CSUM_W-1:0]       CSUM;
    logic [galpal_22V10_pkg::CNT_W-1:0]        BYTE_CNT;
    logic                                      BUSY;
    logic                                      DONE;
    logic                                      ERR;

    modport master (
        output START, D, D_VALID, CSUM_EXP,
        input  D_READY, FUSE, CSUM, BYTE_CNT, BUSY, DONE, ERR
    );

    modport slave (
        input  START, D, D_VALID, CSUM_EXP,
        output D_READY, FUSE, CSUM, BYTE_CNT, BUSY, DONE, ERR
    );

endinterface

// File: rtl/galpal_jed_csum.sv
// JEDEC-style running checksum: sums accepted fuse bytes modulo 2^W.
// Latency: 1 cycle from en_i to csum_o.
// Backpressure: none; the caller qualifies en_i with its own handshake.
// Ports: clk_i/rst_i, clr_i (zero), en_i (add), last_i (keep only byte_i[3:0]), byte_i, csum_o.
module galpal_jed_csum
    import galpal_22V10_pkg::*;
#(
    parameter int W = CSUM_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         last_i,
    input  logic [7:0]   byte_i,
    output logic [W-1:0] csum_o
);

    logic [W-1:0] csum_q;
    logic [W-1:0] csum_d;
    logic [7:0]   byte_m;

    always_comb begin
        // The last byte of the map only carries four real fuses.
        byte_m = last_i ? {4'h0, byte_i[3:0]} : byte_i;
        csum_d = csum_q;
        if (clr_i) begin
            csum_d = '0;
        end else if (en_i) begin
            csum_d = csum_q + W'(byte_m);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;

endmodule

// File: rtl/galpal_22v10_fuse_loader.sv
// Loads the 5892-bit 22V10 fuse map from a byte stream into a held register, then flags done.
// Latency: START to DONE is 739 cycles minimum (1 + 737 bytes + 1 check).
// Backpressure: D_READY high only in LOAD; D_VALID low simply stalls, no timeout.
// Ports: CLK, AR (async active-high reset), bus (slave modport of galpal_22v10_fuse_loader_if).
// Build option GALPAL_FUSE_CSUM_CHECK_EN: compare CSUM to CSUM_EXP in CHECK, bad map -> ERROR.
module galpal_22v10_fuse_loader
    import galpal_22V10_pkg::*;
(
    input logic                        CLK,
    input logic                        AR,
    galpal_22v10_fuse_loader_if.slave  bus
);

    loader_state_t         state_q;
    logic [FUSE_BITS-1:0]  fuse_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  d_ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic [CSUM_W-1:0]     csum;
    logic                  last_byte;
    logic                  xfer;

`ifdef GALPAL_FUSE_CSUM_CHECK_EN
    logic err_q;
    assign bus.ERR = err_q;
`else
    logic unused_csum_exp;
    assign unused_csum_exp = ^bus.CSUM_EXP;
    assign bus.ERR = 1'b0;
`endif

    assign last_byte = (cnt_q == CNT_W'(NBYTES - 1));
    // START wins over a byte offered in the same cycle; that byte is dropped.
    assign xfer      = d_ready_q && bus.D_VALID && !bus.START;

    galpal_jed_csum #(.W(CSUM_W)) u_csum (
        .clk_i  (CLK),
        .rst_i  (AR),
        .clr_i  (bus.START),
        .en_i   (xfer),
        .last_i (last_byte),
        .byte_i (bus.D),
        .csum_o (csum)
    );

    always_ff @(posedge CLK or posedge AR) begin
        if (AR) begin
            state_q   <= ST_IDLE;
            fuse_q    <= '0;
            cnt_q     <= '0;
            d_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef GALPAL_FUSE_CSUM_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else if (bus.START) begin
            state_q   <= ST_LOAD;
            fuse_q    <= '0;
            cnt_q     <= '0;
            d_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
`ifdef GALPAL_FUSE_CSUM_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (xfer) begin
                        for (int k = 0; k < NBYTES - 1; k++) begin
                            if (cnt_q == CNT_W'(k)) begin
                                fuse_q[k*8 +: 8] <= bus.D;
                            end
                        end
                        if (last_byte) begin
                            fuse_q[FUSE_BITS-1 -: 4] <= bus.D[3:0];
                            state_q   <= ST_CHECK;
                            d_ready_q <= 1'b0;
                        end
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    busy_q <= 1'b0;
`ifdef GALPAL_FUSE_CSUM_CHECK_EN
                    if (csum == bus.CSUM_EXP) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        // A map that fails its checksum is never presented.
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                        fuse_q  <= '0;
                    end
`else
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.D_READY  = d_ready_q;
    assign bus.FUSE     = fuse_q;
    assign bus.CSUM     = csum;
    assign bus.BYTE_CNT = cnt_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;

endmodule

// File: tb/tb_galpal_22v10_fuse_loader.sv
// Self-checking bench for galpal_22v10_fuse_loader.
// Expected map/checksum per load is pushed to a scoreboard at START and popped at DONE/ERR.
// Drives on the falling edge, samples just before driving.
module tb_galpal_22v10_fuse_loader;
    import galpal_22V10_pkg::*;

    typedef struct {
        logic [FUSE_BITS-1:0] fuse;
        logic [15:0]          csum;
        logic [9:0]           cnt;
        logic                 done;
        logic                 err;
    } exp_t;

    logic CLK;
    logic AR;
    galpal_22v10_fuse_loader_if bus();

    galpal_22v10_fuse_loader dut (
        .CLK (CLK),
        .AR  (AR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic [7:0] bytes_m [NBYTES];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(output logic [FUSE_BITS-1:0] f, output logic [15:0] s);
        logic [7:0] b;
        f = '0;
        s = '0;
        for (int k = 0; k < NBYTES; k++) begin
            b = bytes_m[k];
            if (k == NBYTES - 1) b[7:4] = 4'h0;
            for (int i = 0; i < 8; i++) begin
                if (k * 8 + i < FUSE_BITS) f[k*8+i] = b[i];
            end
            s = s + {8'h00, b};
        end
    endfunction

    task automatic run_load(input int duty, input logic [15:0] delta, input int abort_at,
                            input bit chk_lat);
        exp_t       e;
        exp_t       g;
        logic [15:0] s;
        int         idx;
        int         cyc;
        bit         vld;
        bit         pend;
        bit         aborted;

        model(e.fuse, s);
        e.csum = s;
        e.cnt  = 10'(NBYTES);
`ifdef GALPAL_FUSE_CSUM_CHECK_EN
        e.done = (delta == 16'd0);
        e.err  = (delta != 16'd0);
        if (delta != 16'd0) e.fuse = '0;
`else
        e.done = 1'b1;
        e.err  = 1'b0;
`endif
        sb_q.push_back(e);

        @(negedge CLK);
        bus.START    = 1'b1;
        bus.D_VALID  = 1'b0;
        bus.CSUM_EXP = s + delta;
        @(negedge CLK);
        bus.START = 1'b0;
        cyc       = 1;
        idx       = 0;
        aborted   = (abort_at < 0);
        while (!(bus.DONE || bus.ERR) && cyc < 6000) begin
            if (!aborted && idx == abort_at) begin
                bus.START   = 1'b1;
                bus.D_VALID = 1'b1;
                bus.D       = bytes_m[idx];
                @(negedge CLK);
                bus.START   = 1'b0;
                bus.D_VALID = 1'b0;
                check_eq("abort_cnt", bus.BYTE_CNT, 0);
                check_eq("abort_csum", bus.CSUM, 0);
                check_eq("abort_fuse_ones", $countones(bus.FUSE), 0);
                check_eq("abort_ready", bus.D_READY, 1);
                aborted = 1'b1;
                idx     = 0;
                cyc     = 1;
            end else begin
                vld         = (idx < NBYTES) && ($urandom_range(99) < duty);
                bus.D_VALID = vld;
                bus.D       = vld ? bytes_m[idx] : 8'($urandom);
                pend        = vld && bus.D_READY;
                @(negedge CLK);
                cyc++;
                if (pend) idx++;
            end
        end
        bus.D_VALID = 1'b0;

        check_eq("terminal_reached", bus.DONE | bus.ERR, 1);
        g = sb_q.pop_front();
        check_eq("done", bus.DONE, g.done);
        check_eq("err", bus.ERR, g.err);
        check_eq("csum", bus.CSUM, g.csum);
        check_eq("byte_cnt", bus.BYTE_CNT, g.cnt);
        check_eq("fuse_diff_bits", $countones(bus.FUSE ^ g.fuse), 0);
        check_eq("busy_end", bus.BUSY, 0);
        check_eq("ready_end", bus.D_READY, 0);
        if (chk_lat) check_eq("latency", cyc, 739);

        // Terminal state must ignore further data.
        bus.D_VALID = 1'b1;
        bus.D       = 8'hA5;
        repeat (3) @(negedge CLK);
        bus.D_VALID = 1'b0;
        check_eq("hold_cnt", bus.BYTE_CNT, g.cnt);
        check_eq("hold_fuse_diff", $countones(bus.FUSE ^ g.fuse), 0);
        check_eq("hold_done", bus.DONE, g.done);
    endtask

    initial begin
        AR           = 1'b1;
        bus.START    = 1'b0;
        bus.D        = 8'h00;
        bus.D_VALID  = 1'b0;
        bus.CSUM_EXP = 16'h0000;
        repeat (2) @(negedge CLK);
        check_eq("rst_fuse_ones", $countones(bus.FUSE), 0);
        check_eq("rst_csum", bus.CSUM, 0);
        check_eq("rst_cnt", bus.BYTE_CNT, 0);
        check_eq("rst_ready", bus.D_READY, 0);
        check_eq("rst_busy", bus.BUSY, 0);
        check_eq("rst_done", bus.DONE, 0);
        check_eq("rst_err", bus.ERR, 0);
        AR = 1'b0;
        @(negedge CLK);
        check_eq("idle_ready", bus.D_READY, 0);

        // Ramp pattern, back to back.
        for (int k = 0; k < NBYTES; k++) bytes_m[k] = 8'(k & 255);
        run_load(100, 16'd0, -1, 1'b1);
        check_eq("ramp_fuse_b0", bus.FUSE[7:0], 8'h00);
        check_eq("ramp_fuse_b1", bus.FUSE[15:8], 8'h01);
        check_eq("ramp_fuse_top", bus.FUSE[5891:5888], 4'h0);
        check_eq("ramp_csum_const", bus.CSUM, 16'h6090);

        // Final byte all ones: only four fuses and 0x0F in the checksum.
        bytes_m[NBYTES-1] = 8'hFF;
        run_load(100, 16'd0, -1, 1'b1);
        check_eq("ff_fuse_top", bus.FUSE[5891:5888], 4'hF);
        check_eq("ff_csum_const", bus.CSUM, 16'h609F);

        // Ramp again with sparse D_VALID.
        bytes_m[NBYTES-1] = 8'hE0;
        run_load(30, 16'd0, -1, 1'b0);
        check_eq("sparse_csum_const", bus.CSUM, 16'h6090);
        check_eq("sparse_fuse_b1", bus.FUSE[15:8], 8'h01);

        // Random data, restart after 100 bytes, then a full reload.
        for (int k = 0; k < NBYTES; k++) bytes_m[k] = 8'($urandom);
        run_load(100, 16'd0, 100, 1'b1);

        // Wrong expected checksum.
        for (int k = 0; k < NBYTES; k++) bytes_m[k] = 8'($urandom);
        run_load(60, 16'd1, -1, 1'b0);

        // Asynchronous reset in the middle of a load.
        @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START   = 1'b0;
        bus.D_VALID = 1'b1;
        bus.D       = 8'h5A;
        repeat (20) @(negedge CLK);
        check_eq("mid_cnt", bus.BYTE_CNT, 20);
        check_eq("mid_csum", bus.CSUM, 16'h0708);
        check_eq("mid_busy", bus.BUSY, 1);
        @(posedge CLK);
        #2;
        AR = 1'b1;
        #1;
        check_eq("ar_ready", bus.D_READY, 0);
        check_eq("ar_busy", bus.BUSY, 0);
        check_eq("ar_cnt", bus.BYTE_CNT, 0);
        check_eq("ar_csum", bus.CSUM, 0);
        check_eq("ar_fuse_ones", $countones(bus.FUSE), 0);
        check_eq("ar_done", bus.DONE, 0);
        @(negedge CLK);
        AR = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("post_ar_ready", bus.D_READY, 0);
        check_eq("post_ar_cnt", bus.BYTE_CNT, 0);
        bus.D_VALID = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/galpal_22v10_fuse_loader.md
Name: galpal_22V10_fuse_loader

Overview:
- Sequencer that loads the 5892-bit 22V10 fuse map from a byte stream into a held fuse register, then asserts done.
- Computes a JEDEC-style 16-bit fuse checksum during the load.
- Its FUSE output drives the FUSE vector of the 22V10 model in benches and soft-GAL builds, so a device can be reprogrammed at runtime instead of only at elaboration.

Parameters:
- FUSE_BITS, 5892, number of fuse bits in the map.
- NBYTES, 737, bytes per map; equals ceil(FUSE_BITS/8).
- CSUM_W, 16, checksum width.

Ports:
- CLK  input  1  clock, rising edge.
- AR  input  1  asynchronous reset, active-high.
- START  input  1  one-cycle pulse; begins a new load.
- D  input  8  fuse data byte. D[0] is the lowest-numbered fuse of the byte.
- D_VALID  input  1  D is valid this cycle.
- D_READY  output  1  loader accepts D this cycle.
- CSUM_EXP  input  16  expected checksum, sampled in CHECK.
- FUSE  output  5892  fuse map; bit n is fuse n.
- CSUM  output  16  running checksum.
- BYTE_CNT  output  10  bytes accepted in the current load.
- BUSY  output  1  high in LOAD or CHECK.
- DONE  output  1  map loaded and accepted.
- ERR  output  1  checksum mismatch.

Behaviour:
- Reset (AR high, asynchronous): state IDLE; FUSE all zeros; CSUM 0; BYTE_CNT 0; D_READY, BUSY, DONE and ERR all 0.
  - All-zero FUSE makes every product term false, so all IOQ outputs are tri-stated.
- States: IDLE, LOAD, CHECK, DONE, ERROR.
- START (any state, including mid-load):
  - Next cycle: state LOAD; FUSE cleared to 0; CSUM 0; BYTE_CNT 0; DONE and ERR 0.
  - START has priority over a simultaneous byte transfer; that byte is discarded.
- LOAD:
  - D_READY = 1. A transfer occurs when D_VALID && D_READY.
  - Byte k is written to FUSE[8k+7:8k] at the clock edge.
  - Final byte (k = NBYTES-1) writes only FUSE[5891:5888] from D[3:0]. D[7:4] is ignored and treated as 0 for the checksum.
  - CSUM <= CSUM + {8'b0, masked byte}, modulo 2^16 (carries wrap).
  - BYTE_CNT increments per transfer.
  - After the transfer of byte NBYTES-1 → CHECK; D_READY drops in the next cycle.
  - D_VALID low: hold; no timeout.
- CHECK: one cycle. BUSY = 1, D_READY = 0, then → DONE (see optional feature).
- DONE: DONE = 1, FUSE held, D_READY = 0. Stays until START or AR.
- ERROR: ERR = 1, FUSE forced to all zeros (a bad map is never presented), D_READY = 0. Stays until START or AR.
- IDLE, DONE, ERROR: D_VALID is ignored.
- BYTE_CNT and CSUM stay readable in DONE and ERROR.
- Latency: from START to DONE is 1 + NBYTES + 1 cycles minimum, i.e. 739.

Optional Feature:
- Macro GALPAL_FUSE_CSUM_CHECK_EN.
- Defined: in CHECK, CSUM is compared to CSUM_EXP. Equal → DONE; unequal → ERROR.
- Undefined: CHECK always → DONE; the ERROR state and comparator are not built; ERR is tied 0. CSUM is still computed and output.

Decomposition:
- Package galpal_22V10_pkg holds:
  - FUSE_BITS and NBYTES;
  - fuse-map row offsets: AR row 0, SP row 5764, OLMC select bits 5808..5827, per-OLMC enable and sum bases;
  - loader state enum.
- One sub-module, galpal_jed_csum: masked byte accumulator with clear and enable, CSUM_W wide.

Test Plan:
- Load bytes k&8'hFF for k = 0..736, with D_VALID held high and CSUM_EXP equal to the true sum → DONE in cycle 739; FUSE[7:0] = 8'h00, FUSE[15:8] = 8'h01; FUSE[5891:5888] = 4'h0 (k = 736, 8'hE0 masked); CSUM matches a model sum.
- Final byte 8'hFF → only FUSE[5891:5888] = 4'hF; CSUM adds 8'h0F, not 8'hFF.
- D_VALID toggled randomly at 30% duty → identical FUSE and CSUM to the back-to-back case; BYTE_CNT = 737 at DONE.
- START pulsed after 100 bytes, coincident with a valid byte → that byte is dropped; FUSE = 0, BYTE_CNT = 0, CSUM = 0; a full reload then reaches DONE.
- With GALPAL_FUSE_CSUM_CHECK_EN, CSUM_EXP = true sum + 1 → ERR = 1, DONE = 0, FUSE all zeros. Without the macro → DONE = 1, ERR = 0.
- AR asserted mid-LOAD between clock edges → outputs take reset values immediately; D_READY = 0 until the next START.
